// File: rtl/teclado_control.sv
// teclado_control: keypad strobe synchronizer/debouncer, key-code executor and
// 32-bit entry register delivered over a valid/ready handshake.
`default_nettype none

module teclado_control #(
  parameter int DEB_CYCLES = 4,
  parameter int MAX_DIG    = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  teclas,
  input  logic        val,
  output logic [31:0] dato,
  output logic [3:0]  num_dig,
  output logic        desborde,
  output logic        dato_valido,
  input  logic        dato_listo,
  output logic        ocupado
);

  localparam logic [3:0] DEB_LAST  = 4'(DEB_CYCLES - 1);
  localparam logic [3:0] DIG_MAX   = 4'(MAX_DIG);
  localparam logic [4:0] COD_ENTER = 5'd16;
  localparam logic [4:0] COD_CLEAR = 5'd17;
  localparam logic [4:0] COD_BORRA = 5'd18;

  typedef enum logic [1:0] {
    ESPERA  = 2'd0,
    SUELTA  = 2'd1,
    ENTREGA = 2'd2
  } estado_t;

  estado_t    estado;
  logic       sync1;
  logic       vs;
  logic       deb;
  logic       bloqueo;
  logic [3:0] cnt;
  logic [4:0] cod;

  logic cambio;
  logic pulsa;
  logic suelta;

  // deb flips on the same edge the counter would reach DEB_CYCLES
  assign cambio = (vs != deb) && (cnt == DEB_LAST);
  assign pulsa  = cambio && !deb && !bloqueo;
  assign suelta = cambio && deb;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // synchronizer starts high so a key held through reset looks already pressed
      sync1       <= 1'b1;
      vs          <= 1'b1;
      deb         <= 1'b0;
      cnt         <= 4'd0;
      bloqueo     <= 1'b1;
      cod         <= 5'd0;
      estado      <= ESPERA;
      dato        <= 32'd0;
      num_dig     <= 4'd0;
      desborde    <= 1'b0;
      dato_valido <= 1'b0;
      ocupado     <= 1'b0;
    end else begin
      sync1 <= val;
      vs    <= sync1;

      if (vs == deb) begin
        cnt <= 4'd0;
      end else if (cambio) begin
        deb <= ~deb;
        cnt <= 4'd0;
      end else begin
        cnt <= cnt + 4'd1;
      end

      // a fresh press is accepted only after the strobe has been seen low
      if ((!vs && !deb) || suelta) begin
        bloqueo <= 1'b0;
      end

      case (estado)
        ESPERA: begin
          if (pulsa) begin
            cod     <= teclas;
            estado  <= SUELTA;
            ocupado <= 1'b1;
          end
        end

        SUELTA: begin
          if (suelta) begin
            estado  <= ESPERA;
            ocupado <= 1'b0;
            if (!cod[4]) begin
              if (num_dig < DIG_MAX) begin
                dato    <= {dato[27:0], cod[3:0]};
                num_dig <= num_dig + 4'd1;
              end else begin
                desborde <= 1'b1;
              end
            end else if (cod == COD_ENTER) begin
              estado      <= ENTREGA;
              ocupado     <= 1'b1;
              dato_valido <= 1'b1;
            end else if (cod == COD_CLEAR) begin
              dato     <= 32'd0;
              num_dig  <= 4'd0;
              desborde <= 1'b0;
            end else if (cod == COD_BORRA) begin
              if (num_dig != 4'd0) begin
                dato    <= dato >> 4;
                num_dig <= num_dig - 4'd1;
              end
            end
          end
        end

        ENTREGA: begin
          if (dato_valido && dato_listo) begin
            dato        <= 32'd0;
            num_dig     <= 4'd0;
            desborde    <= 1'b0;
            dato_valido <= 1'b0;
            estado      <= ESPERA;
            ocupado     <= 1'b0;
          end
        end

        default: begin
          estado  <= ESPERA;
          ocupado <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_teclado_control.sv
// Bench for teclado_control: event-level model checked every cycle plus
// directed literal checks from the test plan.
`default_nettype none

module tb_teclado_control;

  localparam int DEB = 4;
  localparam int MAXD = 8;

  logic        clk;
  logic        reset;
  logic [4:0]  teclas;
  logic        val;
  logic [31:0] dato;
  logic [3:0]  num_dig;
  logic        desborde;
  logic        dato_valido;
  logic        dato_listo;
  logic        ocupado;

  int errors = 0;
  int checks = 0;

  teclado_control #(.DEB_CYCLES(DEB), .MAX_DIG(MAXD)) dut (
    .clk(clk),
    .reset(reset),
    .teclas(teclas),
    .val(val),
    .dato(dato),
    .num_dig(num_dig),
    .desborde(desborde),
    .dato_valido(dato_valido),
    .dato_listo(dato_listo),
    .ocupado(ocupado)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic       m_s1, m_vs, m_deb, m_seen_low, m_press, m_rel, m_desb;
  int         m_run;
  int         m_mode;  // 0 idle, 1 key down, 2 delivering
  logic [4:0] m_cod;
  logic [3:0] m_q[$];

  function automatic logic [31:0] m_dato();
    logic [31:0] d;
    d = 32'd0;
    foreach (m_q[i]) d = (d << 4) | 32'(m_q[i]);
    return d;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      // a key held through reset is treated as already down
      m_s1 = 1'b1; m_vs = 1'b1; m_deb = 1'b0; m_run = 0; m_seen_low = 1'b0;
      m_mode = 0; m_cod = 5'd0; m_q.delete(); m_desb = 1'b0;
    end else begin
      m_press = 1'b0;
      m_rel   = 1'b0;
      if (m_vs != m_deb) begin
        m_run++;
        if (m_run == DEB) begin
          m_deb = ~m_deb;
          m_run = 0;
          if (m_deb) m_press = m_seen_low;
          else       m_rel   = 1'b1;
        end
      end else begin
        m_run = 0;
      end
      if (!m_vs) m_seen_low = 1'b1;
      m_vs = m_s1;
      m_s1 = val;

      case (m_mode)
        0: if (m_press) begin m_cod = teclas; m_mode = 1; end
        1: if (m_rel) begin
             m_mode = 0;
             if (m_cod < 5'd16) begin
               if (m_q.size() < MAXD) m_q.push_back(m_cod[3:0]);
               else m_desb = 1'b1;
             end else if (m_cod == 5'd16) begin
               m_mode = 2;
             end else if (m_cod == 5'd17) begin
               m_q.delete(); m_desb = 1'b0;
             end else if (m_cod == 5'd18) begin
               if (m_q.size() > 0) void'(m_q.pop_back());
             end
           end
        default: if (dato_listo) begin m_q.delete(); m_desb = 1'b0; m_mode = 0; end
      endcase
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("m_dato", dato, m_dato());
    chk("m_num_dig", 32'(num_dig), 32'(m_q.size()));
    chk("m_desborde", 32'(desborde), 32'(m_desb));
    chk("m_dato_valido", 32'(dato_valido), 32'(m_mode == 2));
    chk("m_ocupado", 32'(ocupado), 32'(m_mode != 0));
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic press_key(input logic [4:0] c);
    teclas = c; val = 1'b1; tick(10);
    val = 1'b0; tick(10);
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (!dato_valido && n < 40) begin tick(1); n++; end
    checks++;
    if (!dato_valido) begin
      errors++;
      $display("FAIL wait_valid: dato_valido=0 after 40 cycles, expected 1");
    end
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_dato"}, dato, 32'd0);
    chk({nm, "_num"}, 32'(num_dig), 32'd0);
    chk({nm, "_valido"}, 32'(dato_valido), 32'd0);
    chk({nm, "_ocupado"}, 32'(ocupado), 32'd0);
  endtask

  initial begin
    reset = 1'b0; val = 1'b0; teclas = 5'd0; dato_listo = 1'b0;
    #1 reset = 1'b1;
    tick(3);
    chk_all_zero("reset");
    chk("reset_desborde", 32'(desborde), 32'd0);
    reset = 1'b0;
    tick(5);

    // 1. clean entry
    dato_listo = 1'b1;
    press_key(5'd1); press_key(5'd2); press_key(5'd10);
    teclas = 5'd16; val = 1'b1; tick(10); val = 1'b0;
    wait_valid();
    chk("t1_dato", dato, 32'h0000_012A);
    chk("t1_num", 32'(num_dig), 32'd3);
    tick(1);
    chk("t1_valido_drop", 32'(dato_valido), 32'd0);
    chk("t1_dato_clr", dato, 32'd0);
    chk("t1_num_clr", 32'(num_dig), 32'd0);
    tick(10);

    // 2. bounce then steady hold, then short glitch
    teclas = 5'd5;
    repeat (3) begin val = 1'b1; tick(2); val = 1'b0; tick(2); end
    val = 1'b1; tick(10); val = 1'b0; tick(10);
    chk("t2_dato", dato, 32'h5);
    chk("t2_num", 32'(num_dig), 32'd1);
    val = 1'b1; tick(3); val = 1'b0; tick(10);
    chk("t2_glitch_dato", dato, 32'h5);
    chk("t2_glitch_num", 32'(num_dig), 32'd1);

    // 3. overflow, backspace, clear
    press_key(5'd17);
    for (int k = 1; k <= 9; k++) press_key(5'(k));
    chk("t3_dato", dato, 32'h1234_5678);
    chk("t3_num", 32'(num_dig), 32'd8);
    chk("t3_desb", 32'(desborde), 32'd1);
    press_key(5'd18);
    chk("t3_bs_dato", dato, 32'h0123_4567);
    chk("t3_bs_num", 32'(num_dig), 32'd7);
    chk("t3_bs_desb", 32'(desborde), 32'd1);
    press_key(5'd17);
    chk("t3_clr_dato", dato, 32'd0);
    chk("t3_clr_num", 32'(num_dig), 32'd0);
    chk("t3_clr_desb", 32'(desborde), 32'd0);

    // 4. handshake stall with a press during delivery
    dato_listo = 1'b0;
    press_key(5'd7); press_key(5'd16);
    wait_valid();
    press_key(5'd3);
    chk("t4_valido_hold", 32'(dato_valido), 32'd1);
    chk("t4_dato_hold", dato, 32'h7);
    dato_listo = 1'b1;
    tick(1);
    chk("t4_valido_drop", 32'(dato_valido), 32'd0);
    tick(15);
    chk("t4_num_after", 32'(num_dig), 32'd0);
    chk("t4_ocupado", 32'(ocupado), 32'd0);

    // 5. no-op codes and empty submit
    press_key(5'd18); press_key(5'd25);
    chk("t5_dato", dato, 32'd0);
    chk("t5_num", 32'(num_dig), 32'd0);
    dato_listo = 1'b0;
    press_key(5'd16);
    chk("t5_valido", 32'(dato_valido), 32'd1);
    chk("t5_dato_empty", dato, 32'd0);
    dato_listo = 1'b1;
    tick(3);

    // 6. reset in key-down state and in delivery
    press_key(5'd6);
    chk("t6_pre_dato", dato, 32'h6);
    teclas = 5'd4; val = 1'b1; tick(8);
    chk("t6_suelta", 32'(ocupado), 32'd1);
    #2 reset = 1'b1;
    #1 chk_all_zero("t6_async");
    tick(2);
    reset = 1'b0;
    tick(20);
    chk("t6_held_num", 32'(num_dig), 32'd0);
    chk("t6_held_ocupado", 32'(ocupado), 32'd0);
    val = 1'b0; tick(10);
    chk("t6_release_num", 32'(num_dig), 32'd0);
    press_key(5'd4);
    chk("t6_repress_dato", dato, 32'h4);
    chk("t6_repress_num", 32'(num_dig), 32'd1);
    dato_listo = 1'b0;
    press_key(5'd16);
    chk("t6_entrega", 32'(dato_valido), 32'd1);
    #2 reset = 1'b1;
    #1 chk_all_zero("t6_async2");
    tick(2);
    reset = 1'b0;
    tick(5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
